// File: rtl/logic16_arbiter_pkg.sv
// Shared definitions for the logic16 arbiter slice: opcodes and default datapath width.
package logic16_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

endpackage

// File: rtl/logic16_unit.sv
// Purely combinational bitwise logic unit: NOT, AND, OR and XOR over WIDTH bits.
module logic16_unit
    import logic16_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] not_a;
    logic [WIDTH-1:0] and_ab;
    logic [WIDTH-1:0] or_ab;
    logic [WIDTH-1:0] nand_ab;
    logic [WIDTH-1:0] xor_ab;

    // XOR is composed from the basic gates: (a | b) & ~(a & b)
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign not_a[gi]   = ~a[gi];
            assign and_ab[gi]  = a[gi] & b[gi];
            assign or_ab[gi]   = a[gi] | b[gi];
            assign nand_ab[gi] = ~and_ab[gi];
            assign xor_ab[gi]  = or_ab[gi] & nand_ab[gi];
        end
    endgenerate

    always_comb begin
        y = not_a;
        case (op_e'(op))
            OP_NOT:  y = not_a;
            OP_AND:  y = and_ab;
            OP_OR:   y = or_ab;
            OP_XOR:  y = xor_ab;
            default: y = not_a;
        endcase
    end

endmodule

// File: rtl/logic16_arbiter.sv
// Two-requester round-robin arbiter sharing one logic16_unit, with a one-entry
// tagged result register that supports same-cycle drain and refill.
module logic16_arbiter
    import logic16_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
);

    logic             res_valid_reg;
    logic [WIDTH-1:0] res_data_reg;
    logic             res_id_reg;
    logic             prio_reg;

    logic             slot_free;
    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] unit_y;

    assign slot_free = !res_valid_reg || res_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = prio_reg;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    // Accept is suppressed during reset so an in-flight request is not consumed
    assign accept     = grant_valid && slot_free && !reset;
    assign req0_ready = accept && (grant_id == 1'b0);
    assign req1_ready = accept && (grant_id == 1'b1);

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;

    logic16_unit #(
        .WIDTH(WIDTH)
    ) u_unit (
        .op(sel_op),
        .a (sel_a),
        .b (sel_b),
        .y (unit_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_id_reg    <= 1'b0;
            prio_reg      <= 1'b0;
        end else if (accept) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= unit_y;
            res_id_reg    <= grant_id;
            prio_reg      <= !grant_id;
        end else if (res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;

endmodule
